// File: rtl/sc_statemachine_cursor.sv
// Cursor/point game control FSM: button-driven clear/load/shift strobes, lives counter, game over.
// Optional hold-to-repeat of direction moves under `SC_STATEMACHINECURSOR_AUTOREPEAT_EN.
module sc_statemachine_cursor #(
    parameter int LIVES_INIT    = 3,
    parameter int LIVES_W       = 3,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4,
    parameter int CNT_W         = 24
) (
    input  logic               SC_STATEMACHINECURSOR_CLOCK_50,
    input  logic               SC_STATEMACHINECURSOR_RESET_InHigh,
    input  logic               SC_STATEMACHINECURSOR_startButton_InLow,
    input  logic               SC_STATEMACHINECURSOR_upButton_InLow,
    input  logic               SC_STATEMACHINECURSOR_downButton_InLow,
    input  logic               SC_STATEMACHINECURSOR_leftButton_InLow,
    input  logic               SC_STATEMACHINECURSOR_rightButton_InLow,
    input  logic               SC_STATEMACHINECURSOR_topEdge_InLow,
    input  logic               SC_STATEMACHINECURSOR_bottomEdge_InLow,
    input  logic               SC_STATEMACHINECURSOR_leftEdge_InLow,
    input  logic               SC_STATEMACHINECURSOR_rightEdge_InLow,
    input  logic               SC_STATEMACHINECURSOR_hit_InLow,
    output logic               SC_STATEMACHINECURSOR_clear_OutLow,
    output logic               SC_STATEMACHINECURSOR_load0_OutLow,
    output logic               SC_STATEMACHINECURSOR_load1_OutLow,
    output logic [1:0]         SC_STATEMACHINECURSOR_shiftselection_Out,
    output logic [LIVES_W-1:0] SC_STATEMACHINECURSOR_lives_Out,
    output logic               SC_STATEMACHINECURSOR_gameover_Out
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_START    = 4'd1,
        S_CHECK    = 4'd2,
        S_INIT     = 4'd3,
        S_UP       = 4'd4,
        S_DOWN     = 4'd5,
        S_LEFT     = 4'd6,
        S_RIGHT    = 4'd7,
        S_RELEASE  = 4'd8,
        S_GAMEOVER = 4'd9
    } state_t;

    logic clk, rst;
    assign clk = SC_STATEMACHINECURSOR_CLOCK_50;
    assign rst = SC_STATEMACHINECURSOR_RESET_InHigh;

    logic start_n, up_n, down_n, left_n, right_n, hit_n;
    assign start_n = SC_STATEMACHINECURSOR_startButton_InLow;
    assign up_n    = SC_STATEMACHINECURSOR_upButton_InLow;
    assign down_n  = SC_STATEMACHINECURSOR_downButton_InLow;
    assign left_n  = SC_STATEMACHINECURSOR_leftButton_InLow;
    assign right_n = SC_STATEMACHINECURSOR_rightButton_InLow;
    assign hit_n   = SC_STATEMACHINECURSOR_hit_InLow;

    // A direction counts as pressed only when its edge flag allows the move.
    logic up_ok, down_ok, left_ok, right_ok, all_released;
    assign up_ok    = ~up_n    & SC_STATEMACHINECURSOR_topEdge_InLow;
    assign down_ok  = ~down_n  & SC_STATEMACHINECURSOR_bottomEdge_InLow;
    assign left_ok  = ~left_n  & SC_STATEMACHINECURSOR_leftEdge_InLow;
    assign right_ok = ~right_n & SC_STATEMACHINECURSOR_rightEdge_InLow;
    assign all_released = start_n & up_n & down_n & left_n & right_n;

    state_t              state, state_next;
    logic [LIVES_W-1:0]  lives, lives_next;
    logic                hit_prev, hit_fall, hit_live;

    assign hit_fall = hit_prev & ~hit_n;
    assign hit_live = !(state inside {S_RESET, S_START, S_GAMEOVER});

    always_comb begin
        lives_next = lives;
        if (state == S_INIT)
            lives_next = LIVES_W'(LIVES_INIT);
        else if (hit_fall && hit_live && lives != '0)
            lives_next = lives - 1'b1;
    end

`ifdef SC_STATEMACHINECURSOR_AUTOREPEAT_EN
    state_t           dir;
    logic             rep_phase;
    logic [CNT_W-1:0] timer, thr;
    logic             dir_held, dir_ok, at_thr;

    assign thr    = rep_phase ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
    assign at_thr = (timer == thr);

    always_comb begin
        dir_held = 1'b0;
        dir_ok   = 1'b0;
        case (dir)
            S_UP:    begin dir_held = ~up_n;    dir_ok = up_ok;    end
            S_DOWN:  begin dir_held = ~down_n;  dir_ok = down_ok;  end
            S_LEFT:  begin dir_held = ~left_n;  dir_ok = left_ok;  end
            S_RIGHT: begin dir_held = ~right_n; dir_ok = right_ok; end
            default: ;
        endcase
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_START;
            S_START: state_next = S_CHECK;
            S_CHECK: begin
                if (!start_n)      state_next = S_INIT;
                else if (up_ok)    state_next = S_UP;
                else if (down_ok)  state_next = S_DOWN;
                else if (left_ok)  state_next = S_LEFT;
                else if (right_ok) state_next = S_RIGHT;
            end
            S_INIT, S_UP, S_DOWN, S_LEFT, S_RIGHT: state_next = S_RELEASE;
            S_RELEASE: begin
                if (all_released)
                    state_next = S_CHECK;
`ifdef SC_STATEMACHINECURSOR_AUTOREPEAT_EN
                else if (dir_held && dir_ok && at_thr)
                    state_next = dir;
`endif
            end
            S_GAMEOVER: if (!start_n) state_next = S_INIT;
            default: state_next = S_CHECK;
        endcase
        // Running out of lives beats any button decision.
        if (lives_next == '0 && state != S_GAMEOVER)
            state_next = S_GAMEOVER;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RESET;
            lives    <= LIVES_W'(LIVES_INIT);
            hit_prev <= 1'b1;
        end else begin
            state    <= state_next;
            lives    <= lives_next;
            hit_prev <= hit_n;
        end
    end

`ifdef SC_STATEMACHINECURSOR_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir       <= S_INIT;
            rep_phase <= 1'b0;
            timer     <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    dir       <= S_INIT;
                    rep_phase <= 1'b0;
                    timer     <= '0;
                end
                S_UP, S_DOWN, S_LEFT, S_RIGHT: begin
                    dir   <= state;
                    timer <= '0;
                end
                S_RELEASE: begin
                    if (state_next == S_CHECK) begin
                        rep_phase <= 1'b0;
                        timer     <= '0;
                    end else if (state_next == dir) begin
                        rep_phase <= 1'b1;
                    end else if (dir_held && !dir_ok && at_thr) begin
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

    // Moore decode straight from the state register so async reset idles the strobes at once.
    always_comb begin
        SC_STATEMACHINECURSOR_clear_OutLow       = 1'b1;
        SC_STATEMACHINECURSOR_load0_OutLow       = 1'b1;
        SC_STATEMACHINECURSOR_load1_OutLow       = 1'b1;
        SC_STATEMACHINECURSOR_shiftselection_Out = 2'b11;
        SC_STATEMACHINECURSOR_gameover_Out       = 1'b0;
        case (state)
            S_INIT:     SC_STATEMACHINECURSOR_clear_OutLow       = 1'b0;
            S_UP:       SC_STATEMACHINECURSOR_load0_OutLow       = 1'b0;
            S_DOWN:     SC_STATEMACHINECURSOR_load1_OutLow       = 1'b0;
            S_LEFT:     SC_STATEMACHINECURSOR_shiftselection_Out = 2'b01;
            S_RIGHT:    SC_STATEMACHINECURSOR_shiftselection_Out = 2'b10;
            S_GAMEOVER: SC_STATEMACHINECURSOR_gameover_Out       = 1'b1;
            default: ;
        endcase
    end

    assign SC_STATEMACHINECURSOR_lives_Out = lives;

endmodule

// File: doc/sc_statemachine_cursor.md
Name: sc_statemachine_cursor

Overview:
Parametrised next-generation control FSM for the cursor/point game datapath. It drives clear, vertical-load and horizontal-shift commands to the point register bank from five active-low buttons. Per-edge blocking applies in all four directions, with optional hold-to-repeat. It also owns the lives counter and the game-over condition. Outputs are Moore-decoded from the state register.

Parameters:
LIVES_INIT, 3, lives loaded on reset and on INIT
LIVES_W, 3, width of lives counter (LIVES_INIT < 2**LIVES_W)
REPEAT_DELAY, 8, cycles a direction must be held before first auto-repeat (>=2)
REPEAT_PERIOD, 4, cycles between subsequent auto-repeats (>=2)
CNT_W, 24, repeat timer width (must hold max(REPEAT_DELAY,REPEAT_PERIOD))

Ports:
SC_STATEMACHINECURSOR_CLOCK_50  in  1  system clock
SC_STATEMACHINECURSOR_RESET_InHigh  in  1  reset, asynchronous, active-high
SC_STATEMACHINECURSOR_startButton_InLow  in  1  start/restart
SC_STATEMACHINECURSOR_upButton_InLow  in  1  up
SC_STATEMACHINECURSOR_downButton_InLow  in  1  down
SC_STATEMACHINECURSOR_leftButton_InLow  in  1  left
SC_STATEMACHINECURSOR_rightButton_InLow  in  1  right
SC_STATEMACHINECURSOR_topEdge_InLow  in  1  0 = cursor at top, up blocked
SC_STATEMACHINECURSOR_bottomEdge_InLow  in  1  0 = cursor at bottom, down blocked
SC_STATEMACHINECURSOR_leftEdge_InLow  in  1  0 = left blocked
SC_STATEMACHINECURSOR_rightEdge_InLow  in  1  0 = right blocked
SC_STATEMACHINECURSOR_hit_InLow  in  1  collision flag; falling edge costs one life
SC_STATEMACHINECURSOR_clear_OutLow  out  1  clear point registers
SC_STATEMACHINECURSOR_load0_OutLow  out  1  up load strobe
SC_STATEMACHINECURSOR_load1_OutLow  out  1  down load strobe
SC_STATEMACHINECURSOR_shiftselection_Out  out  2  11 hold, 01 left, 10 right
SC_STATEMACHINECURSOR_lives_Out  out  LIVES_W  remaining lives
SC_STATEMACHINECURSOR_gameover_Out  out  1  1 while in GAMEOVER

Behaviour:
- Reset (async, high): state RESET, clear/load0/load1 = 1, shift = 11, lives = LIVES_INIT, gameover = 0, timer = 0, hit edge register = 1.
- States: RESET -> START -> CHECK unconditionally, one cycle each.
- CHECK priority:
  - start -> INIT
  - up & topEdge=1 -> UP
  - down & bottomEdge=1 -> DOWN
  - left & leftEdge=1 -> LEFT
  - right & rightEdge=1 -> RIGHT
  - else stay in CHECK.
- Blocked directions are treated as not pressed and fall through to the next priority.
- INIT/UP/DOWN/LEFT/RIGHT last exactly one cycle, then go to RELEASE. Direction code is latched on entry; timer is cleared.
- Strobe outputs, all others idle:
  - INIT: clear = 0.
  - UP: load0 = 0.
  - DOWN: load1 = 0.
  - LEFT: shift = 01.
  - RIGHT: shift = 10.
- Latency: button low sampled in CHECK at edge n -> strobe active for cycle n+1 only.
- RELEASE:
  - If all five buttons are high -> CHECK.
  - Otherwise stay, and the timer increments (saturating).
- GAMEOVER: all strobes idle, gameover = 1. Only start is honoured: start -> INIT. Other buttons are ignored.
- Lives: a hit falling edge (registered previous = 1, current = 0) decrements lives, saturating at 0. Hits are ignored in RESET, START and GAMEOVER.
- Reaching 0 lives: forces the next state to GAMEOVER from any state, overriding the button decision.
- INIT reloads lives = LIVES_INIT. A hit edge in the same cycle as INIT is discarded (reload wins).
- Unused state encodings -> CHECK, outputs idle.
- Reset asserted mid-strobe: outputs idle asynchronously, lives reload.

Optional Feature:
Macro SC_STATEMACHINECURSOR_AUTOREPEAT_EN.
- Defined:
  - In RELEASE, if the latched direction button is still low and the timer reaches REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats), re-enter that move state. This gives one strobe and the timer is cleared.
  - If the direction is now blocked by its edge flag, the timer clears and the FSM stays in RELEASE.
  - INIT never repeats.
  - A repeat-phase flag clears on exit to CHECK.
- Undefined: exactly one strobe per press; RELEASE waits for full release; timer logic is absent.

Test Plan:
1. Reset, then up low for 1 cycle in CHECK (topEdge=1) -> load0=0 for exactly one cycle 2 cycles after reset deassert+CHECK sample; then RELEASE until up high -> CHECK.
2. Start and right pressed together -> INIT only (clear=0 one cycle), lives=3, no shift strobe.
3. Down pressed with bottomEdge=0 and left pressed -> LEFT (shift=01), no load1.
4. AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, right held 30 cycles -> shift=10 strobes at relative cycles 1, 10, 15, 20, 25, 30. Without the macro -> single strobe at cycle 1.
5. Three hit falling edges spaced 5 cycles -> lives 3->2->1->0, gameover=1 the cycle after the third. Up pressed -> no strobe. Start -> INIT, lives=3, gameover=0.
6. Hit held low 20 cycles -> exactly one decrement. Reset asserted during a DOWN strobe -> load1=1 immediately, lives=3.
